// File: rtl/display_pkg.sv
// Shared types and segment constants for the BCD display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry n is the pattern for nibble n; 10..15 are not decimal digits and stay dark.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// A result pulse follows BITS+1 cycles after a request is accepted.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS-1:0]       number,
    input  logic                  number_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BITS + 1);

    conv_state_t       state_q, state_d;
    logic [BCD_W-1:0]  sh_bcd_q, sh_bcd_d;
    logic [BITS-1:0]   sh_bin_q, sh_bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              vld_q, vld_d;
    logic [BCD_W-1:0]  adj;

    always_comb begin
        adj = sh_bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sh_bcd_q[4*i +: 4] + 4'd3;
            end
        end

        state_d   = state_q;
        sh_bcd_d  = sh_bcd_q;
        sh_bin_d  = sh_bin_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        vld_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (number_valid) begin
                    sh_bin_d  = number;
                    sh_bcd_d  = '0;
                    cnt_d     = CNT_W'(BITS);
                    ovf_acc_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A carry out of the top nibble means the value needs more digits than we have.
                {sh_bcd_d, sh_bin_d} = {adj[BCD_W-2:0], sh_bin_q, 1'b0};
                ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = sh_bcd_q;
                ovf_d   = ovf_acc_q;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_bcd_q  <= '0;
            sh_bin_q  <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_bcd_q  <= sh_bcd_d;
            sh_bin_q  <= sh_bin_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            vld_q     <= vld_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign bcd       = bcd_q;
    assign bcd_valid = vld_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/bcd_display_driver.sv
// Binary to BCD conversion with a multiplexed active-low 7-segment scanner.
// Define BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_driver
    import display_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS-1:0]       number,
    input  logic                  number_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       digit;

    bin2bcd_seq #(
        .BITS   (BITS),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk          (clk),
        .rst          (rst),
        .number       (number),
        .number_valid (number_valid),
        .busy         (busy),
        .bcd          (bcd),
        .bcd_valid    (bcd_valid),
        .overflow     (overflow)
    );

    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        digit = 4'(bcd >> {idx_q, 2'b00});
        seg   = SEG_LUT[digit];
`ifdef BCD_LEADING_ZERO_BLANK_EN
        // A digit is leading when it and everything above it is zero; digit 0 always shows.
        if ((idx_q != '0) && ((bcd >> {idx_q, 2'b00}) == '0)) begin
            seg = SEG_BLANK;
        end
`else
        seg = seg;
`endif
        if (overflow) begin
            seg = SEG_DASH;
        end
        an = ~(DIGITS'(1) << idx_q);
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: a 3-digit and a 2-digit instance with fast scanning,
// checked against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_display_driver;

    localparam int BITS = 8;
    localparam int D1   = 3;
    localparam int D2   = 2;
    localparam int RDIV = 4;

    localparam logic [6:0] DIGIT_SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] number = '0, number2 = '0;
    logic number_valid = 1'b0, number_valid2 = 1'b0;
    logic busy, busy2, bcd_valid, bcd_valid2, overflow, overflow2;
    logic [11:0] bcd;
    logic [7:0]  bcd2;
    logic [6:0]  seg, seg2;
    logic [2:0]  an;
    logic [1:0]  an2;

    int n_checks = 0, n_fail = 0, cyc = 0, rel_cnt = 0;

    typedef struct { int n; int acc; } exp_t;
    exp_t q1[$], q2[$];
    exp_t e1, e2;
    int disp1 = 0, disp2 = 0;
    bit dovf1 = 0, dovf2 = 0;
    logic [11:0] prev1 = '0;
    logic [7:0]  prev2 = '0;
    logic [2:0]  ean1;
    logic [1:0]  ean2;

    bcd_display_driver #(.BITS(BITS), .DIGITS(D1), .REFRESH_DIV(RDIV)) dut (
        .clk(clk), .rst(rst), .number(number), .number_valid(number_valid),
        .busy(busy), .bcd(bcd), .bcd_valid(bcd_valid), .overflow(overflow),
        .seg(seg), .an(an)
    );

    bcd_display_driver #(.BITS(BITS), .DIGITS(D2), .REFRESH_DIV(RDIV)) dut2 (
        .clk(clk), .rst(rst), .number(number2), .number_valid(number_valid2),
        .busy(busy2), .bcd(bcd2), .bcd_valid(bcd_valid2), .overflow(overflow2),
        .seg(seg2), .an(an2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) rel_cnt <= 0;
        else     rel_cnt <= rel_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r *= 10;
        return r;
    endfunction

    function automatic int to_bcd(input int n, input int d);
        int r = 0;
        int m = n % pow10(d);
        for (int k = 0; k < d; k++) r |= ((m / pow10(k)) % 10) << (4 * k);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int n, input int d, input int i, input bit ovf);
        int m = n % pow10(d);
        if (ovf) return 7'h3F;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (i > 0 && m < pow10(i)) return 7'h7F;
`endif
        return DIGIT_SEG[(m / pow10(i)) % 10];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q1.delete(); disp1 = 0; dovf1 = 0; prev1 = '0;
        end else begin
            if (bcd_valid) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_bcd_valid: got bcd=0x%0h required no pulse (cycle %0d)", bcd, cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("latency", cyc - e1.acc, BITS + 1);
                    chk("bcd", bcd, to_bcd(e1.n, D1));
                    chk("overflow", overflow, e1.n >= pow10(D1));
                    disp1 = e1.n;
                    dovf1 = (e1.n >= pow10(D1));
                end
            end else begin
                chk("bcd_hold", bcd, prev1);
            end
            prev1 = bcd;
            ean1 = ~(3'b001 << ((rel_cnt / RDIV) % D1));
            chk("an", an, ean1);
            chk("seg", seg, exp_seg(disp1, D1, (rel_cnt / RDIV) % D1, dovf1));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q2.delete(); disp2 = 0; dovf2 = 0; prev2 = '0;
        end else begin
            if (bcd_valid2) begin
                if (q2.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_bcd_valid2: got bcd=0x%0h required no pulse (cycle %0d)", bcd2, cyc);
                end else begin
                    e2 = q2.pop_front();
                    chk("latency2", cyc - e2.acc, BITS + 1);
                    chk("bcd2", bcd2, to_bcd(e2.n, D2));
                    chk("overflow2", overflow2, e2.n >= pow10(D2));
                    disp2 = e2.n;
                    dovf2 = (e2.n >= pow10(D2));
                end
            end else begin
                chk("bcd2_hold", bcd2, prev2);
            end
            prev2 = bcd2;
            ean2 = ~(2'b01 << ((rel_cnt / RDIV) % D2));
            chk("an2", an2, ean2);
            chk("seg2", seg2, exp_seg(disp2, D2, (rel_cnt / RDIV) % D2, dovf2));
        end
    end

    task automatic drive1(input int n, output bit acc);
        exp_t t;
        @(negedge clk);
        number = 8'(n);
        number_valid = 1'b1;
        acc = !busy;
        if (acc) begin
            t.n = n; t.acc = cyc + 1;
            q1.push_back(t);
        end
        @(negedge clk);
        number_valid = 1'b0;
    endtask

    task automatic drive2(input int n);
        exp_t t;
        @(negedge clk);
        number2 = 8'(n);
        number_valid2 = 1'b1;
        if (!busy2) begin
            t.n = n; t.acc = cyc + 1;
            q2.push_back(t);
        end
        @(negedge clk);
        number_valid2 = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || busy2) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy || busy2) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy=%0b busy2=%0b required 0 within 100 cycles", busy, busy2);
        end
    endtask

    initial begin
        bit acc;
        int last_acc;
        int n_acc;
        exp_t t;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_bcd_valid", bcd_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_an", an, 3'b110);
        chk("rst_seg", seg, 7'h40);
        chk("rst_an2", an2, 2'b10);
        chk("rst_seg2", seg2, 7'h40);
        rst = 1'b0;

        drive1(255, acc);
        chk("accept_255", acc, 1);
        wait_idle();

        drive1(0, acc);
        wait_idle();
        repeat (14) @(negedge clk);

        drive1(37, acc);
        for (int k = 0; k < 4; k++) begin
            drive1(99, acc);
            chk("ignored_while_busy", acc, 0);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        drive1(99, acc);
        chk("accept_99_idle", acc, 1);
        wait_idle();

        drive2(100);
        wait_idle();
        repeat (10) @(negedge clk);
        drive2(57);
        wait_idle();

        for (int k = 0; k < 30; k++) begin
            drive1(int'($urandom_range(0, 255)), acc);
            drive2(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) drive1(int'($urandom_range(0, 255)), acc);
            wait_idle();
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        last_acc = -1;
        n_acc = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            number = 8'($urandom_range(0, 255));
            number_valid = 1'b1;
            if (!busy) begin
                t.n = int'(number); t.acc = cyc + 1;
                q1.push_back(t);
                if (last_acc >= 0) chk("throughput", t.acc - last_acc, BITS + 2);
                last_acc = t.acc;
                n_acc++;
            end
        end
        @(negedge clk);
        number_valid = 1'b0;
        chk("b2b_accepts", n_acc >= 3, 1);
        wait_idle();

        drive1(200, acc);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_bcd", bcd, 0);
        chk("async_rst_bcd_valid", bcd_valid, 0);
        chk("async_rst_an", an, 3'b110);
        chk("async_rst_seg", seg, 7'h40);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        drive1(128, acc);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", q1.size(), 0);
        chk("queue2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter BITS, 8, width of the unsigned binary value to display.
REQ-002 SHALL have parameter DIGITS, 3, number of BCD digits and display anodes.
REQ-003 SHALL have parameter REFRESH_DIV, 100000, clock cycles each digit stays enabled during scanning.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port number  input  BITS  unsigned value to convert, sampled on acceptance.
REQ-007 SHALL have port number_valid  input  1  request to convert number.
REQ-008 SHALL have port busy  output  1  conversion in progress; requests are ignored while high.
REQ-009 SHALL have port bcd  output  4*DIGITS  last completed BCD result; digit 0 in bits [3:0].
REQ-010 SHALL have port bcd_valid  output  1  one-cycle pulse when bcd updates.
REQ-011 SHALL have port overflow  output  1  last result did not fit in DIGITS digits.
REQ-012 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a} for the enabled digit.
REQ-013 SHALL have port an  output  DIGITS  active-low one-hot digit enables.

Function
REQ-014 SHALL use FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with number_valid=1, capture number, clear the BCD shift register, load iteration count BITS and enter SHIFT.
REQ-016 SHALL, in each SHIFT cycle, add 3 to every nibble >= 5, then shift the {BCD, binary} register left by one.
REQ-017 SHALL enter DONE after exactly BITS SHIFT cycles.
REQ-018 SHALL, in DONE, load bcd and overflow, pulse bcd_valid for one cycle, and return to IDLE.
REQ-019 SHALL assert bcd_valid exactly BITS+1 cycles after the accepting edge; back-to-back throughput is one conversion per BITS+2 cycles.
REQ-020 SHALL ignore, and not queue, number_valid while busy=1.
REQ-021 SHALL set overflow when any 1 bit shifts out of the top nibble; the display then shows a dash (seg=7'h3F) on every digit.
REQ-022 SHALL hold bcd and the displayed value unchanged during a conversion.
REQ-023 SHALL run a refresh counter 0..REFRESH_DIV-1; at terminal count the digit index advances and wraps from DIGITS-1 to 0.
REQ-024 SHALL drive an low only at the current index, and drive seg with the decoded current digit; nibble values 10-15 display blank (7'h7F).

Reset
REQ-025 SHALL, on rst high, immediately force IDLE, bcd=0, bcd_valid=0, overflow=0, refresh count 0, digit index 0, an=~1, seg=7'h40, and abort any conversion without a bcd_valid pulse.

Configuration
REQ-026 SHALL, with BCD_LEADING_ZERO_BLANK_EN defined, blank (7'h7F) each zero digit above the highest non-zero digit, while digit 0 always displays.
REQ-027 SHALL, without BCD_LEADING_ZERO_BLANK_EN, display all digits including leading zeros.

Structure
REQ-028 SHALL place the FSM state enum, the 16-entry segment lookup constant, and the SEG_BLANK and SEG_DASH constants in package display_pkg.
REQ-029 SHALL implement the shift-add converter (REQ-014..019) as sub-module bin2bcd_seq; scanning and decoding stay in the top module.

Verification
REQ-030 SHALL verify BITS=8, DIGITS=3, number=255 pulsed: bcd_valid at cycle 9 with bcd=12'h255 and overflow=0.
REQ-031 SHALL verify number=0: bcd=0; with the macro, digits 2 and 1 seg=7'h7F and digit 0 seg=7'h40; without it, all digits seg=7'h40.
REQ-032 SHALL verify accept 37, then drive 99 while busy: bcd=12'h037; 99 is converted only after it is re-driven in IDLE.
REQ-033 SHALL verify DIGITS=2, number=100: overflow=1 and every digit seg=7'h3F.
REQ-034 SHALL verify REFRESH_DIV=4, DIGITS=3: an cycles 3'b110, 3'b101, 3'b011, 3'b110 with 4 cycles each.
REQ-035 SHALL verify async rst mid-SHIFT: busy drops without waiting for a clock edge, bcd=0, and no bcd_valid pulse occurs.
